// File: rtl/pci_master.sv
// Single-data-phase PCI initiator (memory read/write), all bus outputs registered.
// Latency: ADDR 1 clk after grant seen, done pulse 1 clk after data phase ends; holds in REQ while bus busy, ignores start while busy.
module pci_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mst_start,
  input  logic        mst_iswrite,
  input  logic [31:0] mst_addr,
  input  logic [31:0] mst_wdata,
  input  logic [3:0]  mst_be,
  output logic        mst_busy,
  output logic        mst_done,
  output logic [31:0] mst_rdata,
  output logic [1:0]  mst_status,
  input  logic [31:0] ad_in,
  output logic [31:0] ad_out,
  output logic        ad_en,
  output logic [3:0]  cbe_out,
  output logic        cbe_en,
  output logic        par_out,
  output logic        par_en,
  input  logic        frame_in,
  output logic        frame_out,
  output logic        frame_en,
  input  logic        irdy_in,
  output logic        irdy_out,
  output logic        irdy_en,
  input  logic        trdy_in,
  input  logic        stop_in,
  input  logic        devsel_in,
  output logic        req,
  input  logic        gnt
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_TURN} state_t;

  typedef struct packed {
    logic        iswrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } xact_t;

  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_MABORT  = 2'b01;
  localparam logic [1:0] ST_TABORT  = 2'b10;
  localparam logic [1:0] ST_RETRY   = 2'b11;

  state_t      state_q, state_d;
  xact_t       xact_q, xact_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        busy_d, done_d, ad_en_d, cbe_en_d, par_out_d, par_en_d;
  logic        frame_out_d, frame_en_d, irdy_out_d, irdy_en_d, req_d;
  logic [31:0] rdata_d, ad_out_d;
  logic [3:0]  cbe_out_d;
  logic [1:0]  status_d;
  logic        phase_end;
  logic [1:0]  phase_status;

  always_comb begin
    state_d     = state_q;
    xact_d      = xact_q;
    cnt_d       = cnt_q;
    busy_d      = mst_busy;
    done_d      = 1'b0;
    rdata_d     = mst_rdata;
    status_d    = mst_status;
    ad_out_d    = ad_out;
    ad_en_d     = ad_en;
    cbe_out_d   = cbe_out;
    cbe_en_d    = cbe_en;
    frame_out_d = frame_out;
    frame_en_d  = frame_en;
    irdy_out_d  = irdy_out;
    irdy_en_d   = irdy_en;
    req_d       = req;
    // Parity always trails the AD/CBE it covers by one clock.
    par_out_d   = ^{ad_out, cbe_out};
    par_en_d    = ad_en;
    phase_end    = 1'b0;
    phase_status = ST_OK;

    case (state_q)
      S_IDLE: begin
        if (mst_start) begin
          xact_d  = '{iswrite: mst_iswrite, addr: mst_addr, wdata: mst_wdata, be: mst_be};
          busy_d  = 1'b1;
          req_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!gnt && frame_in && irdy_in) begin
          state_d     = S_ADDR;
          frame_out_d = 1'b0;
          frame_en_d  = 1'b1;
          ad_out_d    = xact_q.addr;
          ad_en_d     = 1'b1;
          cbe_out_d   = xact_q.iswrite ? CMD_MEM_WR : CMD_MEM_RD;
          cbe_en_d    = 1'b1;
          irdy_out_d  = 1'b1;
          irdy_en_d   = 1'b1;
          req_d       = 1'b1;
        end
      end
      S_ADDR: begin
        cnt_d       = 3'd0;
        state_d     = S_DATA;
        frame_out_d = 1'b1;
        irdy_out_d  = 1'b0;
        cbe_out_d   = xact_q.be;
        if (xact_q.iswrite) begin
          ad_out_d = xact_q.wdata;
          ad_en_d  = 1'b1;
        end else begin
          ad_en_d  = 1'b0;
        end
      end
      S_DATA: begin
        if (devsel_in) cnt_d = cnt_q + 3'd1;
        // Target abort outranks everything; master abort only when nobody claimed the cycle.
        if (!stop_in && devsel_in) begin
          phase_end    = 1'b1;
          phase_status = ST_TABORT;
        end else if (!trdy_in && !devsel_in) begin
          phase_end    = 1'b1;
          phase_status = ST_OK;
        end else if (!stop_in && trdy_in) begin
          phase_end    = 1'b1;
          phase_status = ST_RETRY;
        end else if (devsel_in && cnt_q == 3'd4) begin
          phase_end    = 1'b1;
          phase_status = ST_MABORT;
        end
        if (phase_end) begin
          state_d    = S_TURN;
          frame_en_d = 1'b0;
          ad_en_d    = 1'b0;
          cbe_en_d   = 1'b0;
          irdy_out_d = 1'b1;
          done_d     = 1'b1;
          status_d   = phase_status;
          busy_d     = 1'b0;
          if (!xact_q.iswrite && phase_status == ST_OK) rdata_d = ad_in;
        end
      end
      S_TURN: begin
        irdy_en_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      xact_q     <= '0;
      cnt_q      <= 3'd0;
      mst_busy   <= 1'b0;
      mst_done   <= 1'b0;
      mst_rdata  <= 32'd0;
      mst_status <= ST_OK;
      ad_out     <= 32'd0;
      ad_en      <= 1'b0;
      cbe_out    <= 4'd0;
      cbe_en     <= 1'b0;
      par_out    <= 1'b0;
      par_en     <= 1'b0;
      frame_out  <= 1'b1;
      frame_en   <= 1'b0;
      irdy_out   <= 1'b1;
      irdy_en    <= 1'b0;
      req        <= 1'b1;
    end else begin
      state_q    <= state_d;
      xact_q     <= xact_d;
      cnt_q      <= cnt_d;
      mst_busy   <= busy_d;
      mst_done   <= done_d;
      mst_rdata  <= rdata_d;
      mst_status <= status_d;
      ad_out     <= ad_out_d;
      ad_en      <= ad_en_d;
      cbe_out    <= cbe_out_d;
      cbe_en     <= cbe_en_d;
      par_out    <= par_out_d;
      par_en     <= par_en_d;
      frame_out  <= frame_out_d;
      frame_en   <= frame_en_d;
      irdy_out   <= irdy_out_d;
      irdy_en    <= irdy_en_d;
      req        <= req_d;
    end
  end

endmodule

// File: tb/tb_pci_master.sv
// Bench for pci_master: directed vector table, hand sequences for bus-busy and mid-phase reset,
// then randomized target behaviour checked against an outcome model.
module tb_pci_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mst_start, mst_iswrite;
  logic [31:0] mst_addr, mst_wdata;
  logic [3:0]  mst_be;
  logic        mst_busy, mst_done;
  logic [31:0] mst_rdata;
  logic [1:0]  mst_status;
  logic [31:0] ad_in, ad_out;
  logic        ad_en;
  logic [3:0]  cbe_out;
  logic        cbe_en, par_out, par_en;
  logic        frame_in, frame_out, frame_en;
  logic        irdy_in, irdy_out, irdy_en;
  logic        trdy_in, stop_in, devsel_in;
  logic        req, gnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_rdata;

  pci_master dut (
    .clk(clk), .rst_n(rst_n),
    .mst_start(mst_start), .mst_iswrite(mst_iswrite), .mst_addr(mst_addr),
    .mst_wdata(mst_wdata), .mst_be(mst_be), .mst_busy(mst_busy), .mst_done(mst_done),
    .mst_rdata(mst_rdata), .mst_status(mst_status),
    .ad_in(ad_in), .ad_out(ad_out), .ad_en(ad_en),
    .cbe_out(cbe_out), .cbe_en(cbe_en), .par_out(par_out), .par_en(par_en),
    .frame_in(frame_in), .frame_out(frame_out), .frame_en(frame_en),
    .irdy_in(irdy_in), .irdy_out(irdy_out), .irdy_en(irdy_en),
    .trdy_in(trdy_in), .stop_in(stop_in), .devsel_in(devsel_in),
    .req(req), .gnt(gnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    int          dv;    // DATA clock index where DEVSEL# goes low (0 = never)
    int          tr;    // same for TRDY#
    int          st;    // same for STOP#
    logic [31:0] rv;
    int          k;     // expected DATA clocks before completion
    logic [1:0]  status;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Outcome from the bus rules; DEVSEL# is monotonic here, so the no-claim
  // count after k DATA clocks is simply k.
  function automatic void model(input int dv_at, input int tr_at, input int st_at,
                                output int k_out, output logic [1:0] st_out, output bit found);
    found = 0; k_out = 0; st_out = 2'b00;
    for (int k = 1; k <= 12 && !found; k++) begin
      bit dv, tr, st;
      dv = (dv_at != 0) && (k >= dv_at);
      tr = (tr_at != 0) && (k >= tr_at);
      st = (st_at != 0) && (k >= st_at);
      if (st && !dv)       begin found = 1; st_out = 2'b10; end
      else if (tr && dv)   begin found = 1; st_out = 2'b00; end
      else if (st && dv)   begin found = 1; st_out = 2'b11; end
      else if (!dv && k == 5) begin found = 1; st_out = 2'b01; end
      if (found) k_out = k;
    end
  endfunction

  task automatic run_xact(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input int dv_at, input int tr_at, input int st_at,
                          input logic [31:0] rv, input int hold, input logic busy_bus,
                          input int exp_k, input logic [1:0] exp_st);
    logic [3:0] cmd;
    cmd = w ? 4'b0111 : 4'b0110;
    mst_start = 1'b1; mst_iswrite = w; mst_addr = a; mst_wdata = wd; mst_be = be;
    @(negedge clk);
    // Junk start while busy must not disturb the latched request.
    mst_iswrite = ~w; mst_addr = ~a; mst_wdata = ~wd; mst_be = ~be;
    chk("req_busy", {31'd0, mst_busy}, 32'd1);
    chk("req_low", {31'd0, req}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      if (busy_bus) begin
        gnt = 1'b0;
        frame_in = (h == hold - 1);
        irdy_in  = (h != hold - 1);
      end else begin
        gnt = 1'b1;
      end
      @(negedge clk);
      chk("req_hold_frame_en", {31'd0, frame_en}, 32'd0);
      chk("req_hold_req", {31'd0, req}, 32'd0);
    end
    gnt = 1'b0; frame_in = 1'b1; irdy_in = 1'b1;
    @(negedge clk);
    chk("addr_frame", {30'd0, frame_out, frame_en}, 32'd1);
    chk("addr_ad", ad_out, a);
    chk("addr_en", {30'd0, ad_en, cbe_en}, 32'd3);
    chk("addr_cbe", {28'd0, cbe_out}, {28'd0, cmd});
    chk("addr_irdy_req", {29'd0, irdy_out, irdy_en, req}, 32'd7);
    gnt = 1'b1;
    for (int k = 1; k <= exp_k; k++) begin
      @(negedge clk);
      chk("data_frame_irdy", {28'd0, frame_out, frame_en, irdy_out, irdy_en}, 32'hd);
      chk("data_cbe", {28'd0, cbe_out}, {28'd0, be});
      chk("data_ad_en", {31'd0, ad_en}, {31'd0, w});
      chk("data_done", {31'd0, mst_done}, 32'd0);
      if (w) chk("data_ad", ad_out, wd);
      if (k == 1) begin
        chk("addr_par", {30'd0, par_out, par_en}, {30'd0, ^{a, cmd}, 1'b1});
      end else begin
        chk("data_par_en", {31'd0, par_en}, {31'd0, w});
      end
      devsel_in = !((dv_at != 0) && (k >= dv_at));
      trdy_in   = !((tr_at != 0) && (k >= tr_at));
      stop_in   = !((st_at != 0) && (k >= st_at));
      ad_in     = rv;
      if (k == exp_k) mst_start = 1'b0;
    end
    @(negedge clk);
    if (!w && exp_st == 2'b00) last_rdata = rv;
    chk("turn_done", {31'd0, mst_done}, 32'd1);
    chk("turn_status", {30'd0, mst_status}, {30'd0, exp_st});
    chk("turn_busy", {31'd0, mst_busy}, 32'd0);
    chk("turn_release", {29'd0, frame_en, ad_en, cbe_en}, 32'd0);
    chk("turn_irdy", {30'd0, irdy_out, irdy_en}, 32'd3);
    chk("turn_rdata", mst_rdata, last_rdata);
    chk("turn_par_en", {31'd0, par_en}, {31'd0, w});
    if (w) chk("data_par", {31'd0, par_out}, {31'd0, ^{wd, be}});
    trdy_in = 1'b1; stop_in = 1'b1; devsel_in = 1'b1;
    @(negedge clk);
    chk("idle_irdy_en", {31'd0, irdy_en}, 32'd0);
    chk("idle_done", {31'd0, mst_done}, 32'd0);
  endtask

  task automatic reset_in_data();
    mst_start = 1'b1; mst_iswrite = 1'b1; mst_addr = 32'h8000_0040; mst_wdata = 32'hA5A5_0F0F;
    mst_be = 4'h0; gnt = 1'b0;
    @(negedge clk);
    mst_start = 1'b0;
    @(negedge clk);
    gnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_in_data", {30'd0, irdy_out, irdy_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_enables", {27'd0, ad_en, cbe_en, frame_en, irdy_en, par_en}, 32'd0);
    chk("rst_idle_lines", {29'd0, frame_out, irdy_out, req}, 32'd7);
    chk("rst_busy", {31'd0, mst_busy}, 32'd0);
    last_rdata = 32'd0;
    chk("rst_rdata", mst_rdata, last_rdata);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_done", {30'd0, mst_done, mst_busy}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; mst_start = 1'b0; mst_iswrite = 1'b0; mst_addr = '0; mst_wdata = '0; mst_be = '0;
    ad_in = '0; frame_in = 1'b1; irdy_in = 1'b1; trdy_in = 1'b1; stop_in = 1'b1; devsel_in = 1'b1;
    gnt = 1'b1; last_rdata = 32'd0;

    vecs[0] = '{1'b1, 32'h8000_0010, 32'h1234_5678, 4'h0, 2, 2, 0, 32'h0,         2, 2'b00};
    vecs[1] = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 1, 1, 0, 32'hDEAD_BEEF, 1, 2'b00};
    vecs[2] = '{1'b1, 32'h8000_0030, 32'h0BAD_F00D, 4'h3, 0, 0, 0, 32'h0,         5, 2'b01};
    vecs[3] = '{1'b0, 32'h1000_0004, 32'h0,         4'h0, 1, 0, 2, 32'h1111_2222, 2, 2'b11};
    vecs[4] = '{1'b1, 32'h1000_0008, 32'h5555_AAAA, 4'hC, 0, 0, 3, 32'h0,         3, 2'b10};
    vecs[5] = '{1'b0, 32'h2000_0000, 32'h0,         4'h1, 1, 3, 3, 32'hCAFE_0001, 3, 2'b00};
    vecs[6] = '{1'b0, 32'h2000_0010, 32'h0,         4'h0, 5, 5, 0, 32'h7777_8888, 5, 2'b00};
    vecs[7] = '{1'b1, 32'h2000_0020, 32'hFFFF_0000, 4'hF, 6, 6, 0, 32'h0,         5, 2'b01};

    @(negedge clk);
    chk("reset_busy_done", {30'd0, mst_busy, mst_done}, 32'd0);
    chk("reset_rdata", mst_rdata, 32'd0);
    chk("reset_status", {30'd0, mst_status}, 32'd0);
    chk("reset_enables", {27'd0, ad_en, cbe_en, frame_en, irdy_en, par_en}, 32'd0);
    chk("reset_lines", {29'd0, frame_out, irdy_out, req}, 32'd7);
    chk("reset_ad_cbe_par", {ad_out[31:5], cbe_out, par_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_xact(vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].be, vecs[i].dv, vecs[i].tr, vecs[i].st,
               vecs[i].rv, 0, 1'b0, vecs[i].k, vecs[i].status);

    // Bus owned by someone else while granted: must wait for FRAME# and IRDY# both idle.
    run_xact(1'b1, 32'h3000_0000, 32'h0102_0304, 4'h0, 1, 1, 0, 32'h0, 4, 1'b1, 1, 2'b00);

    reset_in_data();

    for (int n = 0; n < 40; n++) begin
      int dv, tr, st, k, hold;
      logic [1:0] es;
      bit found;
      logic w, bb;
      dv = $urandom_range(0, 6); tr = $urandom_range(0, 6); st = $urandom_range(0, 6);
      model(dv, tr, st, k, es, found);
      if (!found) begin
        tr = 7;
        model(dv, tr, st, k, es, found);
      end
      w = 1'($urandom_range(0, 1));
      bb = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      run_xact(w, $urandom, $urandom, 4'($urandom_range(0, 15)), dv, tr, st, $urandom,
               hold, bb, k, es);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
